// File: rtl/imem_program_loader_if.sv
// Byte-stream and instruction-memory write bus of the program loader.
//   in_valid / in_data / in_ready : valid/ready byte stream into the loader
//   imem_we / imem_addr / imem_wdata : one-word-per-cycle write port to imem
// slave = loader side, master = stream source / memory side.
interface imem_program_loader_if #(
    parameter int unsigned AW = 6
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_program_loader.sv
// Boot loader: receives a program as a byte stream (16-bit big-endian word
// count N, then N big-endian 32-bit words), writes it into instruction memory,
// zero-fills the remaining words, then releases the CPU from reset.
//   clock     : system clock, rising edge
//   reset     : asynchronous active-low reset
//   bus       : stream in + imem write port (slave modport)
//   cpu_reset : active-low CPU reset, high only once the load is complete
//   done      : load completed successfully
//   error     : word count exceeded the memory depth
module imem_program_loader #(
    parameter int unsigned INSTR_MEM_SIZE = 64,
    parameter int unsigned AW             = $clog2(INSTR_MEM_SIZE)
) (
    input  logic                  clock,
    input  logic                  reset,
    imem_program_loader_if.slave  bus,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned IW        = AW + 1;
    localparam logic [15:0] MEM_WORDS = 16'(INSTR_MEM_SIZE);
    localparam logic [IW-1:0] IDX_END = IW'(INSTR_MEM_SIZE);

    typedef enum logic [2:0] {
        S_COUNT_HI,
        S_COUNT_LO,
        S_LOAD,
        S_FILL,
        S_RELEASE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          state;
    logic [7:0]      count_hi;
    logic [15:0]     word_cnt;
    logic [IW-1:0]   idx;
    logic [1:0]      byte_cnt;
    logic [23:0]     asm_q;

    logic            ready;
    logic            accept;
    logic [15:0]     n_full;
    logic [IW-1:0]   idx_inc;

    // Ready is a pure decode of the registered state.
    assign ready        = (state == S_COUNT_HI) || (state == S_COUNT_LO) || (state == S_LOAD);
    assign bus.in_ready = ready;
    assign accept       = bus.in_valid && ready;
    assign n_full       = {count_hi, bus.in_data};
    // Index is one bit wider than the address so it can reach the memory depth.
    assign idx_inc      = idx + IW'(1);

    // Loader state machine with registered memory-port and status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= S_COUNT_HI;
            count_hi       <= '0;
            word_cnt       <= '0;
            idx            <= '0;
            byte_cnt       <= '0;
            asm_q          <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            cpu_reset      <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            bus.imem_we <= 1'b0;
            case (state)
                S_COUNT_HI: begin
                    if (accept) begin
                        count_hi <= bus.in_data;
                        state    <= S_COUNT_LO;
                    end
                end
                S_COUNT_LO: begin
                    if (accept) begin
                        word_cnt <= n_full;
                        idx      <= '0;
                        byte_cnt <= '0;
                        if (n_full == 16'd0) begin
                            state <= S_FILL;
                        end else if (n_full <= MEM_WORDS) begin
                            state <= S_LOAD;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (byte_cnt == 2'd3) begin
                            bus.imem_we    <= 1'b1;
                            bus.imem_addr  <= idx[AW-1:0];
                            bus.imem_wdata <= {asm_q, bus.in_data};
                            idx            <= idx_inc;
                            byte_cnt       <= '0;
                            if (16'(idx_inc) == word_cnt) begin
                                state <= (word_cnt < MEM_WORDS) ? S_FILL : S_RELEASE;
                            end
                        end else begin
                            asm_q    <= {asm_q[15:0], bus.in_data};
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                S_FILL: begin
                    bus.imem_we    <= 1'b1;
                    bus.imem_addr  <= idx[AW-1:0];
                    bus.imem_wdata <= '0;
                    idx            <= idx_inc;
                    if (idx_inc == IDX_END) begin
                        state <= S_RELEASE;
                    end
                end
                // Gap cycle so the last write commits before the CPU runs.
                S_RELEASE: begin
                    state <= S_DONE;
                end
                S_DONE: begin
                    done      <= 1'b1;
                    cpu_reset <= 1'b1;
                end
                S_ERROR: begin
                    error     <= 1'b1;
                    cpu_reset <= 1'b0;
                end
                default: begin
                    state <= S_COUNT_HI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Randomized bench for imem_program_loader: two instances (depth 4 and 64)
// checked against a stream-level model of expected writes and release timing.
module tb_imem_program_loader;

    logic clock;
    logic rst_n;

    logic cpu_reset_a, done_a, error_a;
    logic cpu_reset_b, done_b, error_b;

    imem_program_loader_if #(.AW(2)) bus_a ();
    imem_program_loader_if #(.AW(6)) bus_b ();

    imem_program_loader #(.INSTR_MEM_SIZE(4)) dut_a (
        .clock     (clock),
        .reset     (rst_n),
        .bus       (bus_a.slave),
        .cpu_reset (cpu_reset_a),
        .done      (done_a),
        .error     (error_a)
    );

    imem_program_loader #(.INSTR_MEM_SIZE(64)) dut_b (
        .clock     (clock),
        .reset     (rst_n),
        .bus       (bus_b.slave),
        .cpu_reset (cpu_reset_b),
        .done      (done_b),
        .error     (error_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    logic [7:0] stream[$];

    int          wa_addr[$];
    logic [31:0] wa_data[$];
    int          wa_cyc[$];
    int          done_cyc_a;
    int          wb_addr[$];
    logic [31:0] wb_data[$];
    int          wb_cyc[$];
    int          done_cyc_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Record every write and the first cycle done is seen, per instance.
    always @(negedge clock) begin
        if (!rst_n) begin
            wa_addr.delete(); wa_data.delete(); wa_cyc.delete(); done_cyc_a = -1;
            wb_addr.delete(); wb_data.delete(); wb_cyc.delete(); done_cyc_b = -1;
        end else begin
            if (bus_a.imem_we) begin
                wa_addr.push_back(int'(bus_a.imem_addr));
                wa_data.push_back(bus_a.imem_wdata);
                wa_cyc.push_back(cyc);
            end
            if (done_a && done_cyc_a < 0) done_cyc_a = cyc;
            if (bus_b.imem_we) begin
                wb_addr.push_back(int'(bus_b.imem_addr));
                wb_data.push_back(bus_b.imem_wdata);
                wb_cyc.push_back(cyc);
            end
            if (done_b && done_cyc_b < 0) done_cyc_b = cyc;
        end
    end

    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        if (sel == 0) begin bus_a.in_valid = v; bus_a.in_data = d; end
        else          begin bus_b.in_valid = v; bus_b.in_data = d; end
    endtask

    function automatic logic ready_of(input int sel);
        return (sel == 0) ? bus_a.in_ready : bus_b.in_ready;
    endfunction

    function automatic logic finished(input int sel);
        return (sel == 0) ? (done_a | error_a) : (done_b | error_b);
    endfunction

    // Async reset asserted between edges; values must change before any edge.
    task automatic do_reset;
        @(negedge clock);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_ready_a", 32'(bus_a.in_ready), 32'd1);
        check("rst_async_cpu_reset_a", 32'(cpu_reset_a), 32'd0);
        check("rst_async_done_a", 32'(done_a), 32'd0);
        check("rst_async_ready_b", 32'(bus_b.in_ready), 32'd1);
        check("rst_async_cpu_reset_b", 32'(cpu_reset_b), 32'd0);
        check("rst_async_done_b", 32'(done_b), 32'd0);
        repeat (3) @(posedge clock);
        #1;
        check("rst_we_a", 32'(bus_a.imem_we), 32'd0);
        check("rst_error_a", 32'(error_a), 32'd0);
        check("rst_we_b", 32'(bus_b.imem_we), 32'd0);
        check("rst_error_b", 32'(error_b), 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        @(posedge clock);
        #1;
        check("post_rst_ready_a", 32'(bus_a.in_ready), 32'd1);
        check("post_rst_ready_b", 32'(bus_b.in_ready), 32'd1);
    endtask

    // Push the stream bytes with 0..max_gap idle cycles before each one.
    task automatic send(input int sel, input int max_gap);
        logic ok;
        for (int i = 0; i < stream.size(); i++) begin
            repeat ($urandom_range(max_gap, 0)) @(posedge clock);
            #1;
            drive(sel, 1'b1, stream[i]);
            ok = 1'b0;
            for (int t = 0; t < 50 && !ok; t++) begin
                ok = ready_of(sel);
                @(posedge clock);
                #1;
            end
            drive(sel, 1'b0, 8'h00);
            if (!ok) begin
                check("send_timeout", 32'd0, 32'd1);
                return;
            end
        end
    endtask

    task automatic wait_end(input int sel);
        int t;
        for (t = 0; t < 400 && !finished(sel); t++) begin
            @(posedge clock);
            #1;
        end
        if (t == 400) check("end_timeout", 32'd0, 32'd1);
        repeat (4) @(posedge clock);
        #1;
    endtask

    // Model: expected writes are the N stream words followed by zeros up to the
    // depth; done appears two sample cycles after the last write sample.
    task automatic verify(input int sel);
        int          size, n, nw, dcyc;
        int          q_addr[$];
        logic [31:0] q_data[$];
        int          q_cyc[$];
        logic [31:0] exp;
        logic        d, cr, er, rdy;
        size = (sel == 0) ? 4 : 64;
        if (sel == 0) begin
            q_addr = wa_addr; q_data = wa_data; q_cyc = wa_cyc; dcyc = done_cyc_a;
            d = done_a; cr = cpu_reset_a; er = error_a; rdy = bus_a.in_ready;
        end else begin
            q_addr = wb_addr; q_data = wb_data; q_cyc = wb_cyc; dcyc = done_cyc_b;
            d = done_b; cr = cpu_reset_b; er = error_b; rdy = bus_b.in_ready;
        end
        n = {stream[0], stream[1]};
        check("in_ready_after", 32'(rdy), 32'd0);
        if (n > size) begin
            check("err_error", 32'(er), 32'd1);
            check("err_cpu_reset", 32'(cr), 32'd0);
            check("err_done", 32'(d), 32'd0);
            check("err_writes", 32'(q_addr.size()), 32'd0);
            return;
        end
        check("ok_done", 32'(d), 32'd1);
        check("ok_cpu_reset", 32'(cr), 32'd1);
        check("ok_error", 32'(er), 32'd0);
        check("write_count", 32'(q_addr.size()), 32'(size));
        nw = (q_addr.size() < size) ? q_addr.size() : size;
        for (int i = 0; i < nw; i++) begin
            if (i < n) exp = {stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]};
            else       exp = 32'd0;
            check("wr_addr", 32'(q_addr[i]), 32'(i));
            check("wr_data", q_data[i], exp);
            if (i >= n && i > 0) check("fill_back_to_back", 32'(q_cyc[i] - q_cyc[i-1]), 32'd1);
        end
        if (nw > 0) check("release_gap", 32'(dcyc - q_cyc[nw-1]), 32'd2);
    endtask

    task automatic build(input int n, input int nbytes_words);
        stream.delete();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        for (int i = 0; i < 4 * nbytes_words; i++) stream.push_back(8'($urandom));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);

        do_reset();
        stream = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h2A};
        send(0, 0);
        wait_end(0);
        verify(0);

        // Also confirms cpu_reset drops asynchronously from the released state.
        do_reset();
        send(0, 3);
        wait_end(0);
        verify(0);

        do_reset();
        stream = '{8'h00, 8'h00};
        send(1, 0);
        wait_end(1);
        verify(1);

        do_reset();
        stream = '{8'h00, 8'h41};
        send(1, 0);
        wait_end(1);
        verify(1);

        do_reset();
        stream = '{8'h00, 8'h01, 8'hAA, 8'hBB};
        send(0, 0);
        do_reset();
        stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        send(0, 1);
        wait_end(0);
        verify(0);

        for (int it = 0; it < 10; it++) begin
            int sel, size, n;
            sel  = int'($urandom_range(1, 0));
            size = (sel == 0) ? 4 : 64;
            if ($urandom_range(4, 0) == 0) begin
                n = size + 1 + int'($urandom_range(300, 0));
                build(n, 0);
            end else begin
                n = int'($urandom_range(size, 0));
                build(n, n);
            end
            do_reset();
            send(sel, (sel == 0) ? 3 : 1);
            wait_end(sel);
            verify(sel);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
